// File: rtl/smac_engine_ctrl_pkg.sv
// Shared types for the SMAC engine controller: FSM states, config and flag bundles.
package smac_engine_ctrl_pkg;

    localparam int unsigned SMAC_CNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACT     = 3'd1,
        ST_WEI     = 3'd2,
        ST_UPD_IN  = 3'd3,
        ST_DRAIN   = 3'd4,
        ST_UPD_OUT = 3'd5
    } smac_eng_state_t;

    // Configuration handed down by the top-level MAC FSM.
    typedef struct packed {
        logic [SMAC_CNT_W-1:0] len_wei;
        logic [SMAC_CNT_W-1:0] len_out;
        logic [SMAC_CNT_W-1:0] n_acc;
        logic                  start;
    } ctrl_smac_engine_t;

    // Flags returned to the top-level FSM; maps onto flags_engine_t.
    typedef struct packed {
        logic update_in;
        logic update_out;
        logic busy;
    } flags_smac_engine_t;

endpackage

// File: rtl/smac_engine_ctrl_counter.sv
// Up-counter with soft clear, enable and a compare against (limit - 1).
module smac_counter #(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 en_i,
    input  logic [CNT_WIDTH-1:0] limit_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 last_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    assign last_o = (cnt_o == (limit_i - CNT_ONE));

    // Count up on enable, wrapping to zero on the last value so the count never exceeds limit-1.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_o <= '0;
        end else if (clear_i) begin
            cnt_o <= '0;
        end else if (en_i) begin
            cnt_o <= last_o ? '0 : (cnt_o + CNT_ONE);
        end
    end

endmodule

// File: rtl/smac_engine_ctrl.sv
// SMAC engine controller: steers a-stream packets into the datapath, counts passes,
// drains accumulators onto the d-stream and raises update flags for the MAC FSM.
module smac_engine_ctrl
    import smac_engine_ctrl_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 test_mode_i,
    input  logic                 clear_i,
    input  logic                 start_i,
    input  logic [CNT_WIDTH-1:0] len_wei_i,
    input  logic [CNT_WIDTH-1:0] len_out_i,
    input  logic [CNT_WIDTH-1:0] n_acc_i,
    input  logic                 a_valid_i,
    output logic                 a_ready_o,
    output logic                 act_load_o,
    output logic                 wei_valid_o,
    output logic                 acc_clear_o,
    output logic                 d_valid_o,
    input  logic                 d_ready_i,
    output logic [CNT_WIDTH-1:0] d_idx_o,
    output logic                 update_in_o,
    output logic                 update_out_o,
    output logic                 busy_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    // A zero length would never hit its last compare, so it is run as a single packet.
    function automatic logic [CNT_WIDTH-1:0] nz_limit(input logic [CNT_WIDTH-1:0] v);
        return (v == '0) ? CNT_ONE : v;
    endfunction

    smac_eng_state_t    state_q, state_d;
    flags_smac_engine_t flags;

    logic [CNT_WIDTH-1:0] len_wei_q, len_out_q, n_acc_q;
    logic [CNT_WIDTH-1:0] wei_cnt, acc_cnt, out_cnt;
    logic                 wei_last, acc_last, out_last;
    logic                 start_go, act_hs, wei_hs, out_hs;
    logic                 unused_sig;

    // Test mode has no functional effect; the pass counters only matter through their compares.
    assign unused_sig = ^{test_mode_i, wei_cnt, acc_cnt};

    // Handshakes are suppressed on a clear so a dropped pass consumes nothing.
    assign start_go = (state_q == ST_IDLE)  & start_i   & ~clear_i;
    assign act_hs   = (state_q == ST_ACT)   & a_valid_i & ~clear_i;
    assign wei_hs   = (state_q == ST_WEI)   & a_valid_i & ~clear_i;
    assign out_hs   = (state_q == ST_DRAIN) & d_ready_i & ~clear_i;

    smac_counter #(.CNT_WIDTH(CNT_WIDTH)) u_wei_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i | start_go | act_hs),
        .en_i    (wei_hs),
        .limit_i (len_wei_q),
        .cnt_o   (wei_cnt),
        .last_o  (wei_last)
    );

    smac_counter #(.CNT_WIDTH(CNT_WIDTH)) u_acc_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i | start_go | (out_hs & out_last)),
        .en_i    (wei_hs & wei_last & ~acc_last),
        .limit_i (n_acc_q),
        .cnt_o   (acc_cnt),
        .last_o  (acc_last)
    );

    smac_counter #(.CNT_WIDTH(CNT_WIDTH)) u_out_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i | start_go | (wei_hs & wei_last & acc_last)),
        .en_i    (out_hs),
        .limit_i (len_out_q),
        .cnt_o   (out_cnt),
        .last_o  (out_last)
    );

    // Latch the job configuration on the start pulse accepted in IDLE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            len_wei_q <= '0;
            len_out_q <= '0;
            n_acc_q   <= '0;
        end else if (clear_i) begin
            len_wei_q <= '0;
            len_out_q <= '0;
            n_acc_q   <= '0;
        end else if (start_go) begin
            len_wei_q <= nz_limit(len_wei_i);
            len_out_q <= nz_limit(len_out_i);
            n_acc_q   <= nz_limit(n_acc_i);
        end
    end

    // State register; a soft clear always returns to IDLE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else if (clear_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode; update flags depend on state alone.
    always_comb begin
        state_d     = state_q;
        a_ready_o   = 1'b0;
        act_load_o  = 1'b0;
        wei_valid_o = 1'b0;
        acc_clear_o = 1'b0;
        d_valid_o   = 1'b0;
        d_idx_o     = '0;
        flags       = '0;
        flags.busy  = (state_q != ST_IDLE);
        unique case (state_q)
            ST_IDLE: begin
                if (start_go) begin
                    acc_clear_o = 1'b1;
                    state_d     = ST_ACT;
                end
            end
            ST_ACT: begin
                a_ready_o = ~clear_i;
                if (act_hs) begin
                    act_load_o = 1'b1;
                    state_d    = ST_WEI;
                end
            end
            ST_WEI: begin
                a_ready_o = ~clear_i;
                if (wei_hs) begin
                    wei_valid_o = 1'b1;
                    if (wei_last) begin
                        state_d = acc_last ? ST_DRAIN : ST_UPD_IN;
                    end
                end
            end
            ST_UPD_IN: begin
                flags.update_in = 1'b1;
                state_d         = ST_ACT;
            end
            ST_DRAIN: begin
                d_valid_o = ~clear_i;
                d_idx_o   = clear_i ? '0 : out_cnt;
                if (out_hs && out_last) begin
                    state_d = ST_UPD_OUT;
                end
            end
            ST_UPD_OUT: begin
                flags.update_out = 1'b1;
                acc_clear_o      = 1'b1;
                state_d          = ST_ACT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign update_in_o  = flags.update_in;
    assign update_out_o = flags.update_out;
    assign busy_o       = flags.busy;

endmodule

// File: doc/smac_engine_ctrl.md
Name: smac_engine_ctrl

Overview:
- Low-level engine controller sitting between the streamer and the SMAC datapath, directly below the top-level MAC FSM.
- Per pass, it consumes the a-stream as one activation packet followed by len_wei weight packets. It steers those packets into the datapath and counts accumulation passes.
- After n_acc passes it drains the accumulators onto the d-stream as len_out packets.
- It raises the update_in/update_out flags that the top-level FSM uses to advance the ucode indices and re-program the streamers.

Parameters:
- CNT_WIDTH, 16, width of the len_wei, len_out and n_acc counters and config inputs.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- test_mode_i  in  1  test mode; no functional effect
- clear_i  in  1  synchronous soft clear; same effect as reset
- start_i  in  1  one-cycle start pulse from the slave; latches config
- len_wei_i  in  CNT_WIDTH  weight packets per pass
- len_out_i  in  CNT_WIDTH  output packets per drain
- n_acc_i  in  CNT_WIDTH  passes per output
- a_valid_i  in  1  a-stream valid
- a_ready_o  out  1  a-stream ready
- act_load_o  out  1  datapath captures the current a-packet as activations
- wei_valid_o  out  1  datapath multiply-accumulates the current a-packet as weights
- acc_clear_o  out  1  clear accumulators
- d_valid_o  out  1  d-stream valid
- d_ready_i  in  1  d-stream ready
- d_idx_o  out  CNT_WIDTH  accumulator slice selected for the current output packet
- update_in_o  out  1  flags_engine.update_in pulse
- update_out_o  out  1  flags_engine.update_out pulse
- busy_o  out  1  high in any state other than IDLE

Behaviour:
- Reset and clear_i:
  - State goes to IDLE and all counters to 0.
  - All outputs are 0 at reset.
  - clear_i has priority over every other event. A clear mid-pass drops the pass with no flag pulse.
- Config latch:
  - On start_i in IDLE, latch len_wei, len_out and n_acc.
  - A latched value of 0 is treated as 1.
  - start_i outside IDLE is ignored.
- States: IDLE, ACT, WEI, UPD_IN, DRAIN, UPD_OUT.
- IDLE:
  - a_ready_o=0.
  - On start_i: acc_clear_o=1 for that cycle, then go to ACT.
- ACT:
  - a_ready_o=1.
  - On a handshake (a_valid_i & a_ready_o): act_load_o=1 combinationally in the same cycle, wei_cnt<=0, go to WEI.
- WEI:
  - a_ready_o=1.
  - On each handshake: wei_valid_o=1 combinationally and wei_cnt increments.
  - On the handshake with wei_cnt==len_wei-1:
    - if acc_cnt==n_acc-1, go to DRAIN with out_cnt<=0;
    - otherwise acc_cnt increments and the next state is UPD_IN.
- UPD_IN:
  - update_in_o=1 for exactly this cycle; a_ready_o=0.
  - Next state is ACT unconditionally.
- DRAIN:
  - d_valid_o=1, d_idx_o=out_cnt, a_ready_o=0.
  - Each d-handshake increments out_cnt.
  - On the handshake with out_cnt==len_out-1: acc_cnt<=0, next state UPD_OUT.
  - d_valid_o stays high and d_idx_o stays stable while d_ready_i=0.
- UPD_OUT:
  - update_out_o=1 and acc_clear_o=1 for exactly this cycle.
  - Next state is ACT.
- Termination: the engine never self-terminates. The top-level FSM ends the job via ucode done, and the engine returns to IDLE only on clear_i.
- Latency:
  - update_in_o asserts exactly 1 cycle after the last weight handshake.
  - update_out_o asserts exactly 1 cycle after the last output handshake.
- Output timing:
  - act_load_o, wei_valid_o, acc_clear_o in IDLE, a_ready_o and d_valid_o are decoded from state and inputs.
  - update_in_o, update_out_o and acc_clear_o in UPD_OUT are driven only by their state, so they are glitch-free.
- Counters wrap only through the explicit compares above. No counter ever exceeds its latched limit minus one.
- Ready policy: a_ready_o is never asserted in DRAIN. No a-packet may be consumed while outputs are pending.

Decomposition:
- In mac_package:
  - typedef smac_eng_state_t;
  - struct ctrl_smac_engine_t {len_wei, len_out, n_acc, start};
  - struct flags_smac_engine_t {update_in, update_out, busy}, which maps onto flags_engine_t.
- Sub-module smac_counter: CNT_WIDTH up-counter with clear, enable, a limit input and a last_o compare. Instantiated three times (wei, acc, out).

Test Plan:
- Reset held with a_valid_i=1 -> all outputs 0. Release, start_i with len_wei=3, n_acc=2, len_out=2 -> acc_clear_o pulse, then a_ready_o=1.
- Full job, continuous valid, same config:
  - act_load_o once, wei_valid_o ×3, update_in_o in cycle 5;
  - second pass, then DRAIN with d_idx_o 0,1;
  - update_out_o together with acc_clear_o 1 cycle after the second d-handshake.
- a_valid_i toggled every other cycle in WEI -> wei_valid_o only on handshake cycles. update_in_o still exactly 1 cycle after the 3rd weight.
- d_ready_i held low 4 cycles in DRAIN -> d_valid_o=1 and d_idx_o=0 stable, a_ready_o=0 throughout.
- Config len_wei=0, n_acc=0, len_out=0 -> behaves as 1/1/1:
  - act, one weight, DRAIN with one output, update_out_o;
  - update_in_o is never asserted.
- clear_i asserted mid-WEI and mid-DRAIN -> next cycle IDLE, busy_o=0, no update pulses. A new start_i runs a correct job.
